// File: rtl/uart_rx.sv
// UART 8-bit receiver (1 start, 8 data LSB-first, optional even parity, 1 stop) with valid/ready output.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BAUD_RATE = 57600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam int          CYCLE    = CLK_FRE / BAUD_RATE;
  localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] CNT_MID  = 16'(CYCLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4, S_PARITY = 3'd5
  } state_t;

  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    even_parity_ok = (^{data, par}) == 1'b0;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4
  } state_t;
`endif

  state_t      state_r, state_n;
  logic [15:0] cnt_r, cnt_n, cnt_keep_s;
  logic [2:0]  bit_cnt_r, bit_cnt_n;
  logic [7:0]  shreg_r, shreg_n;
  logic        sync1_r, sync2_r, rx_s;
  logic        load_s, frame_err_s, overrun_s, parity_err_s;
`ifdef UART_RX_PARITY_EN
  logic        par_r, par_n;
`endif

  assign rx_s = sync2_r;

  // Next-state, datapath and event strobes; cnt restarts whenever the state changes
  always_comb begin
    state_n      = state_r;
    cnt_keep_s   = cnt_r + 16'd1;
    bit_cnt_n    = bit_cnt_r;
    shreg_n      = shreg_r;
    load_s       = 1'b0;
    frame_err_s  = 1'b0;
    overrun_s    = 1'b0;
    parity_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n        = par_r;
`endif
    case (state_r)
      S_IDLE: begin
        cnt_keep_s = 16'd0;
        bit_cnt_n  = 3'd0;
        if (!rx_s) state_n = S_START;
        else       state_n = S_IDLE;
      end
      S_START: begin
        if (cnt_r == CNT_MID && rx_s) state_n = S_IDLE;
        else if (cnt_r == CNT_LAST)   state_n = S_DATA;
        else                          state_n = S_START;
      end
      S_DATA: begin
        if (cnt_r == CNT_MID) shreg_n[bit_cnt_r] = rx_s;
        else                  shreg_n = shreg_r;
        if (cnt_r == CNT_LAST) begin
          cnt_keep_s = 16'd0;
          bit_cnt_n  = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_r == CNT_MID) par_n = rx_s;
        else                  par_n = par_r;
        if (cnt_r == CNT_LAST) state_n = S_STOP;
        else                   state_n = S_PARITY;
      end
`endif
      // Decide at mid stop bit so a following start edge is never missed
      S_STOP: begin
        if (cnt_r == CNT_MID) begin
          if (!rx_s) begin
            frame_err_s = 1'b1;
            state_n     = S_BREAK;
          end
`ifdef UART_RX_PARITY_EN
          else if (!even_parity_ok(shreg_r, par_r)) begin
            parity_err_s = 1'b1;
            state_n      = S_IDLE;
          end
`endif
          else if (rx_data_valid && !rx_data_ready) begin
            overrun_s = 1'b1;
            state_n   = S_IDLE;
          end else begin
            load_s  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_STOP;
        end
      end
      S_BREAK: begin
        cnt_keep_s = 16'd0;
        if (rx_s) state_n = S_IDLE;
        else      state_n = S_BREAK;
      end
      default: begin
        state_n    = S_IDLE;
        cnt_keep_s = 16'd0;
      end
    endcase
    cnt_n = (state_n != state_r) ? 16'd0 : cnt_keep_s;
  end

  // Synchronizer, FSM state, output register and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r       <= 1'b1;
      sync2_r       <= 1'b1;
      state_r       <= S_IDLE;
      cnt_r         <= 16'd0;
      bit_cnt_r     <= 3'd0;
      shreg_r       <= 8'd0;
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      sync1_r      <= rx_pin;
      sync2_r      <= sync1_r;
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      bit_cnt_r    <= bit_cnt_n;
      shreg_r      <= shreg_n;
      rx_frame_err <= frame_err_s;
      rx_overrun   <= overrun_s;
      if (load_s) begin
        rx_data       <= shreg_r;
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end else begin
        rx_data_valid <= rx_data_valid;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity sample and error pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      par_r         <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      par_r         <= par_n;
      rx_parity_err <= parity_err_s;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CYCLE=10: stimulus pushes expected bytes, a monitor pops on accept.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       rx_data_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_frame_err, rx_overrun, rx_parity_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FRE(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic par_bad, input logic stop, input int stop_clks);
    rx_pin = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      tick(10);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = (^d) ^ par_bad;
    tick(10);
`else
    if (par_bad) $display("note: parity request ignored in 8N1 build");
`endif
    rx_pin = stop;
    tick(stop_clks);
    rx_pin = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop on every accepted byte, count error pulses, flag simultaneous errors
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!rst) begin
      if (rx_data_valid && rx_data_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no byte", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_byte: got %02h, required %02h", rx_data, exp);
          end
        end
      end
      fe_cnt += int'(rx_frame_err);
      ov_cnt += int'(rx_overrun);
      pe_cnt += int'(rx_parity_err);
      if (rx_frame_err || rx_overrun || rx_parity_err) begin
        checks++;
        if (int'(rx_frame_err) + int'(rx_overrun) + int'(rx_parity_err) > 1) begin
          errors++;
          $display("FAIL flags_exclusive: got fe=%b ov=%b pe=%b, required at most one", rx_frame_err, rx_overrun, rx_parity_err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish within 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, ov0, pe0;
    logic ok;

    tick(3);
    check("reset_valid", 32'(rx_data_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_flags", {29'd0, rx_frame_err, rx_overrun, rx_parity_err}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 0x55 held while ready is low, then accepted
    rx_data_ready = 1'b0;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b0, 1'b1, 10);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!(rx_data_valid === 1'b1 && rx_data === 8'h55)) ok = 1'b0;
    end
    check("hold_55", 32'(ok), 32'd1);
    rx_data_ready = 1'b1;
    tick(1);
    check("valid_drop_after_accept", 32'(rx_data_valid), 32'd0);
    wait_drain();

    // 3-clock glitch, then 0xA3
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(30);
    check("glitch_no_valid", 32'(rx_data_valid), 32'd0);
    check("glitch_no_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0), 32'd0);
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b0, 1'b1, 10);
    wait_drain();

    // 0xC3 with low stop and 40-clock break, then 0x3C
    fe0 = fe_cnt;
    send(8'hC3, 1'b0, 1'b0, 40);
    tick(20);
    check("break_one_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("break_no_valid", 32'(rx_data_valid), 32'd0);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0, 1'b1, 10);
    wait_drain();

    // Back-to-back 0x01, 0x02 without accept: overrun, first byte kept
    ov0 = ov_cnt;
    rx_data_ready = 1'b0;
    exp_q.push_back(8'h01);
    send(8'h01, 1'b0, 1'b1, 10);
    send(8'h02, 1'b0, 1'b1, 10);
    tick(5);
    check("overrun_data_kept", 32'(rx_data), 32'h01);
    check("overrun_valid", 32'(rx_data_valid), 32'd1);
    check("overrun_pulse", 32'(ov_cnt - ov0), 32'd1);
    rx_data_ready = 1'b1;
    wait_drain();
    tick(5);
    check("overrun_no_second", 32'(rx_data_valid), 32'd0);

    // Reset during bit 4 of 0xFF, then 0x81
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rx_pin = 1'b0;
    tick(10);
    rx_pin = 1'b1;
    tick(45);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midreset_data", 32'(rx_data), 32'd0);
    check("midreset_valid", 32'(rx_data_valid), 32'd0);
    check("midreset_flags", {29'd0, rx_frame_err, rx_overrun, rx_parity_err}, 32'd0);
    tick(60);
    check("midreset_no_pulses", 32'(fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0), 32'd0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b0, 1'b1, 10);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity 1 accepted, with parity 0 rejected
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send(8'h07, 1'b0, 1'b1, 10);
    wait_drain();
    send(8'h07, 1'b1, 1'b1, 10);
    tick(20);
    check("parity_err_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("parity_no_valid", 32'(rx_data_valid), 32'd0);
`else
    check("parity_tied_low", 32'(pe_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
